defect_classifier_roi: RTL and testbench

- Per-frame defect classifier for the binarised Canny edge stream.
- Counts edge pixels inside a parametrised region of interest (ROI) and tracks their bounding box.
- At end of frame, classifies the frame as patch, scratch or nice against run-time thresholds.
- Sits after the Canny/binarisation stage; results go to the display overlay and the UART report.

---
 rtl/defect_classifier_roi.sv | 193 +++++++++++++++++++
 tb/tb_defect_classifier_roi.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/defect_classifier_roi.sv
// Per-frame edge-pixel counter with bounding box over a fixed region of interest,
// classifying each completed frame as patch, scratch or nice.
module defect_classifier_roi #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int POS_W   = 10,
   parameter int COUNT_W = 20,
   parameter int ROI_X0  = 0,
   parameter int ROI_Y0  = 0,
   parameter int ROI_X1  = IMG_W - 1,
   parameter int ROI_Y1  = IMG_H - 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               per_frame_clken,
   input  logic [POS_W-1:0]   x_pos,
   input  logic [POS_W-1:0]   y_pos,
   input  logic               per_img_Bit,
   input  logic [COUNT_W-1:0] thr_patch,
   input  logic [COUNT_W-1:0] thr_scratch,
   output logic [2:0]         classification,
   output logic               class_valid,
   output logic [COUNT_W-1:0] pixel_count,
   output logic [POS_W-1:0]   bbox_x_min,
   output logic [POS_W-1:0]   bbox_x_max,
   output logic [POS_W-1:0]   bbox_y_min,
   output logic [POS_W-1:0]   bbox_y_max,
   output logic               bbox_valid,
   output logic               frame_abort
);

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

   state_t state, state_next;

   int   x_i, y_i;
   logic start_pix, last_pix, in_roi, hit;
   logic init_acc, acc_en, snap_en, decide_en, abort_set;

   logic [COUNT_W-1:0] count_acc, base_count, upd_count, snap_count;
   logic [POS_W-1:0]   x_min_acc, x_max_acc, y_min_acc, y_max_acc;
   logic [POS_W-1:0]   base_x_min, base_x_max, base_y_min, base_y_max;
   logic [POS_W-1:0]   upd_x_min, upd_x_max, upd_y_min, upd_y_max;
   logic [POS_W-1:0]   snap_x_min, snap_x_max, snap_y_min, snap_y_max;
   logic [COUNT_W-1:0] shadow_patch, shadow_scratch;

   // Positions are compared as signed ints so ROI bounds at 0 stay warning-free.
   assign x_i       = int'(x_pos);
   assign y_i       = int'(y_pos);
   assign start_pix = per_frame_clken && (x_i == 0) && (y_i == 0);
   assign last_pix  = per_frame_clken && (x_i == IMG_W - 1) && (y_i == IMG_H - 1);
   assign in_roi    = (x_i >= ROI_X0) && (x_i <= ROI_X1) && (y_i >= ROI_Y0) && (y_i <= ROI_Y1);
   assign hit       = per_frame_clken && per_img_Bit && in_roi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      init_acc   = 1'b0;
      acc_en     = 1'b0;
      snap_en    = 1'b0;
      decide_en  = 1'b0;
      abort_set  = 1'b0;
      case (state)
         IDLE: begin
            if (start_pix) begin
               state_next = ACCUM;
               init_acc   = 1'b1;
               acc_en     = 1'b1;
            end
         end
         ACCUM: begin
            acc_en = 1'b1;
            if (start_pix) begin
               init_acc  = 1'b1;
               abort_set = 1'b1;
            end else if (last_pix) begin
               snap_en    = 1'b1;
               state_next = DECIDE;
            end
         end
         DECIDE: begin
            decide_en = 1'b1;
            // A back-to-back start pixel opens the next frame while this one is decided.
            if (start_pix) begin
               state_next = ACCUM;
               init_acc   = 1'b1;
               acc_en     = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The start pixel is counted on top of freshly initialised accumulators.
   always_comb begin
      base_count = init_acc ? '0 : count_acc;
      base_x_min = init_acc ? '1 : x_min_acc;
      base_x_max = init_acc ? '0 : x_max_acc;
      base_y_min = init_acc ? '1 : y_min_acc;
      base_y_max = init_acc ? '0 : y_max_acc;
      upd_count  = base_count;
      upd_x_min  = base_x_min;
      upd_x_max  = base_x_max;
      upd_y_min  = base_y_min;
      upd_y_max  = base_y_max;
      if (hit) begin
         if (base_count != '1)    upd_count = base_count + COUNT_W'(1);
         if (x_pos < base_x_min)  upd_x_min = x_pos;
         if (x_pos > base_x_max)  upd_x_max = x_pos;
         if (y_pos < base_y_min)  upd_y_min = y_pos;
         if (y_pos > base_y_max)  upd_y_max = y_pos;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_acc      <= '0;
         x_min_acc      <= '0;
         x_max_acc      <= '0;
         y_min_acc      <= '0;
         y_max_acc      <= '0;
         shadow_patch   <= '0;
         shadow_scratch <= '0;
         snap_count     <= '0;
         snap_x_min     <= '0;
         snap_x_max     <= '0;
         snap_y_min     <= '0;
         snap_y_max     <= '0;
      end else begin
         if (acc_en) begin
            count_acc <= upd_count;
            x_min_acc <= upd_x_min;
            x_max_acc <= upd_x_max;
            y_min_acc <= upd_y_min;
            y_max_acc <= upd_y_max;
         end
         if (init_acc) begin
            shadow_patch   <= thr_patch;
            shadow_scratch <= thr_scratch;
         end
         if (snap_en) begin
            snap_count <= upd_count;
            snap_x_min <= upd_x_min;
            snap_x_max <= upd_x_max;
            snap_y_min <= upd_y_min;
            snap_y_max <= upd_y_max;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         classification <= 3'b000;
         class_valid    <= 1'b0;
         pixel_count    <= '0;
         bbox_x_min     <= '0;
         bbox_x_max     <= '0;
         bbox_y_min     <= '0;
         bbox_y_max     <= '0;
         bbox_valid     <= 1'b0;
         frame_abort    <= 1'b0;
      end else begin
         class_valid <= decide_en;
         frame_abort <= abort_set;
         if (decide_en) begin
            pixel_count <= snap_count;
            if (snap_count > shadow_patch)        classification <= 3'b001;
            else if (snap_count > shadow_scratch) classification <= 3'b010;
            else                                  classification <= 3'b100;
            if (snap_count == '0) begin
               bbox_valid <= 1'b0;
               bbox_x_min <= '0;
               bbox_x_max <= '0;
               bbox_y_min <= '0;
               bbox_y_max <= '0;
            end else begin
               bbox_valid <= 1'b1;
               bbox_x_min <= snap_x_min;
               bbox_x_max <= snap_x_max;
               bbox_y_min <= snap_y_min;
               bbox_y_max <= snap_y_max;
            end
         end
      end
   end

endmodule

// File: tb/tb_defect_classifier_roi.sv
// Bench for defect_classifier_roi: three configurations share one pixel stream;
// a frame-level reference model feeds per-instance expected queues.
module tb_defect_classifier_roi;

   localparam int W  = 16;
   localparam int H  = 8;
   localparam int PW = 10;
   localparam int CMAX_BIG = (1 << 20) - 1;

   // Handshake: every class_valid pulse presents exactly one frame result,
   // which is held on the outputs until the next pulse.
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clken = 1'b0;
   logic [PW-1:0] x_pos = '0;
   logic [PW-1:0] y_pos = '0;
   logic bit_in = 1'b0;
   logic [19:0] thr_p = '0;
   logic [19:0] thr_s = '0;
   logic [3:0]  thr_pc = '0;
   logic [3:0]  thr_sc = '0;

   logic [2:0] cls_a, cls_b, cls_c;
   logic cv_a, cv_b, cv_c, bv_a, bv_b, bv_c, ab_a, ab_b, ab_c;
   logic [19:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;
   logic [PW-1:0] xmin_a, xmax_a, ymin_a, ymax_a;
   logic [PW-1:0] xmin_b, xmax_b, ymin_b, ymax_b;
   logic [PW-1:0] xmin_c, xmax_c, ymin_c, ymax_c;

   typedef struct packed {
      logic [2:0]    cls;
      logic [19:0]   cnt;
      logic [PW-1:0] xmin;
      logic [PW-1:0] xmax;
      logic [PW-1:0] ymin;
      logic [PW-1:0] ymax;
      logic          bv;
   } res_t;

   res_t got_a, got_b, got_c;
   res_t exp_a[$];
   res_t exp_b[$];
   res_t exp_c[$];

   int compared = 0;
   int mismatched = 0;
   int exp_aborts = 0;
   int ab_seen_a = 0, ab_seen_b = 0, ab_seen_c = 0;
   logic fr [H][W];

   assign got_a = {cls_a, cnt_a, xmin_a, xmax_a, ymin_a, ymax_a, bv_a};
   assign got_b = {cls_b, cnt_b, xmin_b, xmax_b, ymin_b, ymax_b, bv_b};
   assign got_c = {cls_c, 16'd0, cnt_c, xmin_c, xmax_c, ymin_c, ymax_c, bv_c};

   defect_classifier_roi #(.IMG_W(W), .IMG_H(H), .POS_W(PW), .COUNT_W(20)) dut_a (
      .clk(clk), .rst_n(rst_n), .per_frame_clken(clken), .x_pos(x_pos), .y_pos(y_pos),
      .per_img_Bit(bit_in), .thr_patch(thr_p), .thr_scratch(thr_s),
      .classification(cls_a), .class_valid(cv_a), .pixel_count(cnt_a),
      .bbox_x_min(xmin_a), .bbox_x_max(xmax_a), .bbox_y_min(ymin_a), .bbox_y_max(ymax_a),
      .bbox_valid(bv_a), .frame_abort(ab_a));

   defect_classifier_roi #(.IMG_W(W), .IMG_H(H), .POS_W(PW), .COUNT_W(20),
                           .ROI_X0(4), .ROI_X1(7), .ROI_Y0(1), .ROI_Y1(6)) dut_b (
      .clk(clk), .rst_n(rst_n), .per_frame_clken(clken), .x_pos(x_pos), .y_pos(y_pos),
      .per_img_Bit(bit_in), .thr_patch(thr_p), .thr_scratch(thr_s),
      .classification(cls_b), .class_valid(cv_b), .pixel_count(cnt_b),
      .bbox_x_min(xmin_b), .bbox_x_max(xmax_b), .bbox_y_min(ymin_b), .bbox_y_max(ymax_b),
      .bbox_valid(bv_b), .frame_abort(ab_b));

   defect_classifier_roi #(.IMG_W(W), .IMG_H(H), .POS_W(PW), .COUNT_W(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .per_frame_clken(clken), .x_pos(x_pos), .y_pos(y_pos),
      .per_img_Bit(bit_in), .thr_patch(thr_pc), .thr_scratch(thr_sc),
      .classification(cls_c), .class_valid(cv_c), .pixel_count(cnt_c),
      .bbox_x_min(xmin_c), .bbox_x_max(xmax_c), .bbox_y_min(ymin_c), .bbox_y_max(ymax_c),
      .bbox_valid(bv_c), .frame_abort(ab_c));

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic res_t model(input int x0, input int x1, input int y0, input int y1,
                                  input int cmax, input int tp, input int ts);
      int n, c, xl, xh, yl, yh;
      res_t r;
      n = 0; xl = W; xh = -1; yl = H; yh = -1;
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            if (fr[yy][xx] && xx >= x0 && xx <= x1 && yy >= y0 && yy <= y1) begin
               n++;
               if (xx < xl) xl = xx;
               if (xx > xh) xh = xx;
               if (yy < yl) yl = yy;
               if (yy > yh) yh = yy;
            end
      c = (n > cmax) ? cmax : n;
      r = '0;
      r.cnt = 20'(c);
      if (c > tp)      r.cls = 3'b001;
      else if (c > ts) r.cls = 3'b010;
      else             r.cls = 3'b100;
      if (n > 0) begin
         r.bv = 1'b1;
         r.xmin = PW'(xl);
         r.xmax = PW'(xh);
         r.ymin = PW'(yl);
         r.ymax = PW'(yh);
      end
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic cmp_res(input string name, input res_t got, input res_t exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got cls=%b cnt=%0d x=%0d..%0d y=%0d..%0d bv=%b, expected cls=%b cnt=%0d x=%0d..%0d y=%0d..%0d bv=%b",
                  name, got.cls, got.cnt, got.xmin, got.xmax, got.ymin, got.ymax, got.bv,
                  exp.cls, exp.cnt, exp.xmin, exp.xmax, exp.ymin, exp.ymax, exp.bv);
      end
   endtask

   task automatic unexpected(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: class_valid pulsed with no frame result expected", name);
   endtask

   always @(negedge clk) begin
      if (cv_a) begin
         if (exp_a.size() == 0) unexpected("unexpected_a");
         else cmp_res("result_a", got_a, exp_a.pop_front());
      end
      if (cv_b) begin
         if (exp_b.size() == 0) unexpected("unexpected_b");
         else cmp_res("result_b", got_b, exp_b.pop_front());
      end
      if (cv_c) begin
         if (exp_c.size() == 0) unexpected("unexpected_c");
         else cmp_res("result_c", got_c, exp_c.pop_front());
      end
      if (ab_a) ab_seen_a++;
      if (ab_b) ab_seen_b++;
      if (ab_c) ab_seen_c++;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_pix(input int px, input int py, input logic b);
      @(posedge clk); #1;
      clken = 1'b1;
      x_pos = PW'(px);
      y_pos = PW'(py);
      bit_in = b;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      clken = 1'b0;
      x_pos = PW'($urandom_range(0, W - 1));
      y_pos = PW'($urandom_range(0, H - 1));
      bit_in = 1'($urandom_range(0, 1));
   endtask

   task automatic junk_pixels(input int n);
      int px, py;
      for (int i = 0; i < n; i++) begin
         px = $urandom_range(0, W - 1);
         py = $urandom_range(0, H - 1);
         if (px == 0 && py == 0) px = 1;
         drive_pix(px, py, 1'b1);
      end
   endtask

   task automatic clear_frame();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++) fr[yy][xx] = 1'b0;
   endtask

   task automatic scatter(input int n);
      int px, py, k;
      clear_frame();
      k = 0;
      while (k < n) begin
         px = $urandom_range(0, W - 1);
         py = $urandom_range(0, H - 1);
         if (!fr[py][px]) begin
            fr[py][px] = 1'b1;
            k++;
         end
      end
   endtask

   // stop_line < 0 drives the whole frame and queues its result.
   task automatic run_frame(input int stop_line, input bit thr_mid);
      int tp, ts, tpc, tsc;
      tp = int'(thr_p); ts = int'(thr_s); tpc = int'(thr_pc); tsc = int'(thr_sc);
      for (int yy = 0; yy < H; yy++) begin
         if (yy == stop_line) return;
         for (int xx = 0; xx < W; xx++) begin
            if (thr_mid && yy == H / 2 && xx == 0) begin
               thr_p = 20'($urandom_range(0, 60));
               thr_s = 20'($urandom_range(0, 60));
               thr_pc = 4'($urandom_range(0, 15));
               thr_sc = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 4) == 0) idle_cycle();
            drive_pix(xx, yy, fr[yy][xx]);
         end
      end
      exp_a.push_back(model(0, W - 1, 0, H - 1, CMAX_BIG, tp, ts));
      exp_b.push_back(model(4, 7, 1, 6, CMAX_BIG, tp, ts));
      exp_c.push_back(model(0, W - 1, 0, H - 1, 15, tpc, tsc));
   endtask

   task automatic wait_drain(input string tag);
      int n;
      @(posedge clk); #1;
      clken = 1'b0;
      n = 0;
      while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      compared++;
      if ((exp_a.size() + exp_b.size() + exp_c.size()) != 0) begin
         mismatched++;
         $display("FAIL drain_%s: pending results a=%0d b=%0d c=%0d, expected 0 0 0",
                  tag, exp_a.size(), exp_b.size(), exp_c.size());
         exp_a.delete(); exp_b.delete(); exp_c.delete();
      end
   endtask

   task automatic check_reset(input string tag);
      cmp_res({tag, "_a"}, got_a, '0);
      cmp_res({tag, "_b"}, got_b, '0);
      cmp_res({tag, "_c"}, got_c, '0);
      compared++;
      if ({cv_a, cv_b, cv_c, ab_a, ab_b, ab_c} !== 6'b0) begin
         mismatched++;
         $display("FAIL %s_pulses: got valid=%b%b%b abort=%b%b%b, expected all 0",
                  tag, cv_a, cv_b, cv_c, ab_a, ab_b, ab_c);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      clear_frame();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      #1 rst_n = 1'b1;

      // Dense random frame, patch class.
      thr_p = 20'd20; thr_s = 20'd5; thr_pc = 4'd10; thr_sc = 4'd3;
      scatter(30);
      run_frame(-1, 1'b0);
      wait_drain("t1");

      // One line of 12 edges, scratch class.
      clear_frame();
      for (int xx = 2; xx <= 13; xx++) fr[3][xx] = 1'b1;
      run_frame(-1, 1'b0);
      wait_drain("t2");
      cmp_res("t2_direct", got_a, res_t'{cls:3'b010, cnt:20'd12, xmin:10'd2, xmax:10'd13,
                                         ymin:10'd3, ymax:10'd3, bv:1'b1});

      // Empty frame.
      clear_frame();
      run_frame(-1, 1'b0);
      wait_drain("t3");
      cmp_res("t3_direct", got_a, res_t'{cls:3'b100, cnt:20'd0, xmin:10'd0, xmax:10'd0,
                                         ymin:10'd0, ymax:10'd0, bv:1'b0});

      // Full line of edges, narrow ROI on instance b.
      clear_frame();
      for (int xx = 0; xx < W; xx++) fr[2][xx] = 1'b1;
      run_frame(-1, 1'b0);
      junk_pixels(5);
      wait_drain("t4");
      cmp_res("t4_direct", got_b, res_t'{cls:3'b100, cnt:20'd4, xmin:10'd4, xmax:10'd7,
                                         ymin:10'd2, ymax:10'd2, bv:1'b1});

      // Truncated frame restarted at line 4, then a complete 6-pixel frame.
      scatter(40);
      run_frame(4, 1'b0);
      scatter(6);
      exp_aborts++;
      run_frame(-1, 1'b0);
      wait_drain("t5a");

      // Thresholds changed mid-frame must not affect the result.
      clear_frame();
      for (int xx = 2; xx <= 13; xx++) fr[3][xx] = 1'b1;
      thr_p = 20'd20; thr_s = 20'd5;
      run_frame(-1, 1'b1);
      wait_drain("t5b");
      cmp_res("t5_latched_thr", got_a, res_t'{cls:3'b010, cnt:20'd12, xmin:10'd2, xmax:10'd13,
                                              ymin:10'd3, ymax:10'd3, bv:1'b1});

      // Saturation on the 4-bit instance.
      thr_pc = 4'd15; thr_sc = 4'd3;
      scatter(20);
      run_frame(-1, 1'b0);
      wait_drain("t6a");
      compared++;
      if (cnt_c !== 4'd15) begin
         mismatched++;
         $display("FAIL t6_saturate: got pixel_count=%0d, expected 15", cnt_c);
      end

      // Reset in the middle of a frame: no result for it.
      scatter(25);
      run_frame(5, 1'b0);
      @(posedge clk); #1;
      clken = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) idle_cycle();
      scatter(9);
      run_frame(-1, 1'b0);
      wait_drain("t6b");

      // Randomised frames with random thresholds, gaps, junk and restarts.
      for (int i = 0; i < 25; i++) begin
         int dens;
         dens = $urandom_range(0, 100);
         for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) fr[yy][xx] = ($urandom_range(0, 99) < dens);
         thr_p = 20'($urandom_range(0, 130));
         thr_s = 20'($urandom_range(0, 130));
         thr_pc = 4'($urandom_range(0, 15));
         thr_sc = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) begin
            run_frame($urandom_range(1, H - 1), 1'b0);
            exp_aborts++;
         end
         run_frame(-1, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 3) == 0) junk_pixels($urandom_range(1, 6));
      end
      wait_drain("final");

      compared++;
      if (ab_seen_a != exp_aborts || ab_seen_b != exp_aborts || ab_seen_c != exp_aborts) begin
         mismatched++;
         $display("FAIL abort_count: got a=%0d b=%0d c=%0d, expected %0d",
                  ab_seen_a, ab_seen_b, ab_seen_c, exp_aborts);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      mismatched++;
      $display("FAIL global_timeout: simulation did not complete within the time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
